// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and the canonical bubble word.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // addi x0,x0,0 -- architecturally a no-op, used for every bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // An all-zero word is treated as the end-of-program marker.
  function automatic logic is_halt_word(input logic [31:0] word);
    return (word == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
module if_id_reg #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            valid_out
);

  logic [XLEN-1:0] pc_p0;
  logic [31:0]     instr_p0;
  logic            vld_p0;

  // Stage IF -> ID: a flush turns the slot into a bubble but keeps the last PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0    <= '0;
      instr_p0 <= NOP_INSTR;
      vld_p0   <= 1'b0;
    end else if (flush) begin
      instr_p0 <= NOP_INSTR;
      vld_p0   <= 1'b0;
    end else if (load) begin
      pc_p0    <= pc_in;
      instr_p0 <= instr_in;
      vld_p0   <= 1'b1;
    end
  end

  assign pc_out    = pc_p0;
  assign instr_out = instr_p0;
  assign valid_out = vld_p0;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC sequencing, branch redirect, zero-word halt with
// a drain window that lets an older in-flight branch still redirect fetch.
module instr_fetch_stage #(
  parameter int          XLEN         = 64,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] NOP_INSTR    = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            IF_ID_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] IF_ID_pc_out,
  output logic [31:0]     instr_IF_ID,
  output logic            if_id_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  import pipeline_pkg::*;

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic [CNT_W-1:0] drain_cnt, cnt_nx;
  logic [31:0]     fetch_cnt, fcnt_nx;
  logic            ifid_load, ifid_flush;

  // Next-state, next-PC and IF/ID control; HALT ignores everything but reset.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    cnt_nx     = drain_cnt;
    fcnt_nx    = fetch_cnt;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state != ST_HALT && branch_taken) begin
      state_nx   = ST_RUN;
      pc_nx      = branch_target;
      cnt_nx     = '0;
      ifid_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          // A stalled zero word is re-examined once the stall lifts.
          if (pc_write && is_halt_word(imem_rdata)) begin
            state_nx   = ST_DRAIN;
            cnt_nx     = CNT_W'(DRAIN_CYCLES);
            ifid_flush = IF_ID_write;
          end else begin
            if (pc_write) pc_nx = pc + XLEN'(4);
            if (IF_ID_write) begin
              ifid_load = 1'b1;
              fcnt_nx   = fetch_cnt + 32'd1;
            end
          end
        end
        ST_DRAIN: begin
          ifid_flush = IF_ID_write;
          if (drain_cnt <= CNT_W'(1)) begin
            state_nx = ST_HALT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = drain_cnt - CNT_W'(1);
          end
        end
        ST_HALT: ifid_flush = 1'b1;
        default: state_nx = ST_RUN;
      endcase
    end
  end

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= '0;
      drain_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drain_cnt <= cnt_nx;
      fetch_cnt <= fcnt_nx;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .pc_in     (pc),
    .instr_in  (imem_rdata),
    .pc_out    (IF_ID_pc_out),
    .instr_out (instr_IF_ID),
    .valid_out (if_id_valid)
  );

  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign instr       = (state == ST_RUN) ? imem_rdata : NOP_INSTR;
  assign halted      = (state == ST_HALT);
  assign fetch_count = fetch_cnt;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam int M_FETCH = 0;
  localparam int M_WAIT  = 1;
  localparam int M_STOP  = 2;

  logic        clk = 1'b0;
  logic        reset, pc_write, IF_ID_write, branch_taken;
  logic [63:0] branch_target;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr, pc_out, IF_ID_pc_out;
  logic [31:0] instr, instr_IF_ID, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [0:255];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  int          m_mode;
  int          m_left;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_iw, m_fc, m_w;
  logic        m_iv;

  always #5 clk = ~clk;

  always_comb imem_rdata = mem[imem_addr[9:2]];

  instr_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .IF_ID_write   (IF_ID_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .pc_out        (pc_out),
    .instr         (instr),
    .IF_ID_pc_out  (IF_ID_pc_out),
    .instr_IF_ID   (instr_IF_ID),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what fetch must do this edge, from the rules.
  always @(posedge clk) begin
    m_w = mem[m_pc[9:2]];
    if (reset) begin
      m_mode = M_FETCH; m_left = 0; m_pc = '0; m_ipc = '0;
      m_iw = NOP; m_iv = 1'b0; m_fc = '0;
    end else if (m_mode == M_STOP) begin
      m_iw = NOP; m_iv = 1'b0;
    end else if (branch_taken) begin
      m_mode = M_FETCH; m_left = 0; m_pc = branch_target;
      m_iw = NOP; m_iv = 1'b0;
    end else if (m_mode == M_FETCH) begin
      if (pc_write && m_w == 32'h0) begin
        m_mode = M_WAIT; m_left = 3;
        if (IF_ID_write) begin m_iw = NOP; m_iv = 1'b0; end
      end else begin
        if (IF_ID_write) begin
          m_ipc = m_pc; m_iw = m_w; m_iv = 1'b1; m_fc = m_fc + 1;
        end
        if (pc_write) m_pc = m_pc + 64'd4;
      end
    end else begin
      if (IF_ID_write) begin m_iw = NOP; m_iv = 1'b0; end
      m_left = m_left - 1;
      if (m_left <= 0) begin m_mode = M_STOP; m_left = 0; end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc_out, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("instr", {32'h0, instr}, {32'h0, (m_mode == M_FETCH) ? mem[m_pc[9:2]] : NOP});
      check("IF_ID_pc_out", IF_ID_pc_out, m_ipc);
      check("instr_IF_ID", {32'h0, instr_IF_ID}, {32'h0, m_iw});
      check("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_iv});
      check("halted", {63'h0, halted}, {63'h0, (m_mode == M_STOP)});
      check("fetch_count", {32'h0, fetch_count}, {32'h0, m_fc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc_out, 64'h0);
    check({tag, "_ifpc"}, IF_ID_pc_out, 64'h0);
    check({tag, "_iw"}, {32'h0, instr_IF_ID}, {32'h0, NOP});
    check({tag, "_iv"}, {63'h0, if_id_valid}, 64'h0);
    check({tag, "_halted"}, {63'h0, halted}, 64'h0);
    check({tag, "_fc"}, {32'h0, fetch_count}, 64'h0);
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b1; IF_ID_write = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = ADDI;

    // Reset and straight-line fetch
    tick();
    chk_en = 1'b1;
    check_reset_state("rst");
    reset = 1'b0;
    repeat (4) tick();
    check("seq_pc", pc_out, 64'h10);
    check("seq_fc", {32'h0, fetch_count}, 64'd4);
    check("seq_ifpc", IF_ID_pc_out, 64'h0C);

    // Stall at 0x08
    do_reset();
    repeat (2) tick();
    check("stall_pre_pc", pc_out, 64'h08);
    pc_write = 1'b0; IF_ID_write = 1'b0;
    repeat (2) tick();
    check("stall_pc", pc_out, 64'h08);
    check("stall_iw", {32'h0, instr_IF_ID}, {32'h0, ADDI});
    check("stall_fc", {32'h0, fetch_count}, 64'd2);
    pc_write = 1'b1; IF_ID_write = 1'b1;
    tick();
    check("resume_pc", pc_out, 64'h0C);
    check("resume_fc", {32'h0, fetch_count}, 64'd3);

    // Flush wins over stall
    branch_taken = 1'b1; branch_target = 64'h40; IF_ID_write = 1'b0;
    tick();
    check("br_pc", pc_out, 64'h40);
    check("br_iw", {32'h0, instr_IF_ID}, {32'h0, NOP});
    check("br_iv", {63'h0, if_id_valid}, 64'h0);
    branch_taken = 1'b0; IF_ID_write = 1'b1;

    // Zero word at 0x20 -> drain -> halt
    mem[8] = 32'h0;
    do_reset();
    repeat (8) tick();
    check("z_pc", pc_out, 64'h20);
    check("z_instr", {32'h0, instr}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_pc", pc_out, 64'h20);
      check("drain_halted", {63'h0, halted}, 64'h0);
    end
    check("drain_instr", {32'h0, instr}, {32'h0, NOP});
    tick();
    check("halt_halted", {63'h0, halted}, 64'h1);
    branch_taken = 1'b1; branch_target = 64'h80;
    repeat (2) tick();
    check("halt_br_halted", {63'h0, halted}, 64'h1);
    check("halt_br_pc", pc_out, 64'h20);
    check("halt_fc", {32'h0, fetch_count}, 64'd8);

    // Reset from HALT, with a branch pending
    reset = 1'b1;
    tick();
    check_reset_state("rst_halt");
    reset = 1'b0; branch_taken = 1'b0;

    // Branch during the second drain cycle rescues fetch
    repeat (8) tick();
    tick();
    tick();
    branch_taken = 1'b1; branch_target = 64'h80;
    tick();
    check("rescue_halted", {63'h0, halted}, 64'h0);
    check("rescue_pc", pc_out, 64'h80);
    branch_taken = 1'b0;
    tick();
    check("rescue_next_pc", pc_out, 64'h84);
    check("rescue_fc", {32'h0, fetch_count}, 64'd9);
    check("rescue_ifpc", IF_ID_pc_out, 64'h80);

    // Reset from DRAIN, while stalled
    do_reset();
    repeat (9) tick();
    reset = 1'b1; pc_write = 1'b0; IF_ID_write = 1'b0;
    tick();
    check_reset_state("rst_drain");
    reset = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1;

    // PC wraps silently at the top of the address space
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    check("wrap_pc", pc_out, 64'h0);
    check("wrap_ifpc", IF_ID_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 99) < 4) ? 32'h0 : $urandom;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset         = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      pc_write      = ($urandom_range(0, 4) != 0);
      IF_ID_write   = ($urandom_range(0, 4) != 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC and branch-target width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles a zero-word halt waits for an older branch to resolve.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, bubble word (addi x0,x0,0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_write  input  1  hazard unit; 0 holds PC.
REQ-007 IF_ID_write  input  1  hazard unit; 0 holds IF/ID register.
REQ-008 branch_taken  input  1  redirect from MEM stage (branch & zero flag).
REQ-009 branch_target  input  XLEN  redirect address.
REQ-010 imem_rdata  input  32  instruction word at imem_addr, combinational same-cycle read.
REQ-011 imem_addr  output  XLEN  equals pc_out.
REQ-012 pc_out  output  XLEN  current fetch PC.
REQ-013 instr  output  32  fetched word (imem_rdata, or NOP_INSTR when not in RUN).
REQ-014 IF_ID_pc_out  output  XLEN  PC held in IF/ID.
REQ-015 instr_IF_ID  output  32  instruction held in IF/ID.
REQ-016 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 halted  output  1  state is HALT.
REQ-018 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-019 SHALL implement states RUN, DRAIN, HALT.
REQ-020 In RUN, each cycle with pc_write=1 and no branch_taken SHALL set PC to PC+4 (modulo 2^XLEN, wrap silent).
REQ-021 branch_taken=1 SHALL set PC to branch_target next cycle regardless of pc_write, IF_ID_write or state (except HALT).
REQ-022 branch_taken=1 SHALL load IF/ID with NOP_INSTR, if_id_valid=0, regardless of IF_ID_write (flush priority over stall).
REQ-023 IF_ID_write=1, no flush, RUN: IF/ID SHALL load {pc_out, imem_rdata}, if_id_valid=1, fetch_count+1.
REQ-024 IF_ID_write=0, no flush: IF/ID, if_id_valid and fetch_count SHALL hold.
REQ-025 RUN with imem_rdata==0, no branch_taken, pc_write=1 SHALL go to DRAIN, freeze PC, load counter with DRAIN_CYCLES; zero word not accepted into IF/ID.
REQ-026 In DRAIN, PC SHALL hold; IF/ID SHALL load NOP_INSTR with if_id_valid=0 when IF_ID_write=1; counter decrements each cycle.
REQ-027 DRAIN with branch_taken=1 SHALL return to RUN at branch_target next cycle.
REQ-028 DRAIN with counter reaching 0 and no branch_taken SHALL enter HALT; simultaneous branch_taken wins.
REQ-029 HALT SHALL be exited only by reset; PC, fetch_count frozen; IF/ID NOP, valid 0; branch_taken ignored.
REQ-030 pc_write=0 in RUN with imem_rdata==0 SHALL NOT enter DRAIN (decision deferred to unstalled cycle).
REQ-031 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-032 reset SHALL force, next edge: state RUN, pc_out 0, IF_ID_pc_out 0, instr_IF_ID NOP_INSTR, if_id_valid 0, halted 0, fetch_count 0, drain counter 0.
REQ-033 reset SHALL take priority over branch_taken, stall and every state, including mid-DRAIN and HALT.

Structure
REQ-034 State encoding and NOP_INSTR SHALL live in shared package pipeline_pkg, reused by decode/hazard logic.
REQ-035 IF/ID register (load, hold, flush) SHALL be sub-module if_id_reg; PC, FSM and counters stay top-level.

Verification
REQ-036 Reset, imem returns 32'h00500093 every address, 4 cycles -> pc_out 0x10, fetch_count 4, IF_ID_pc_out 0x0C.
REQ-037 pc_write=0, IF_ID_write=0 at pc 0x08 for 2 cycles -> pc_out, instr_IF_ID, fetch_count unchanged; resumes 0x0C.
REQ-038 branch_taken=1, target 0x40, with IF_ID_write=0 same cycle -> pc_out 0x40, instr_IF_ID 32'h00000013, if_id_valid 0.
REQ-039 imem 0 at 0x20, no branch -> DRAIN, pc_out stays 0x20 for 3 cycles, then halted=1 and remains 1 under branch_taken.
REQ-040 imem 0 at 0x20, branch_taken target 0x80 on second DRAIN cycle -> halted stays 0, pc_out 0x80, RUN resumes.
REQ-041 reset asserted during HALT and during DRAIN -> all outputs match REQ-032 next cycle.
